// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register and ALU operand driver for the pipelined MIPS core.
//   It latches the decoded fields from ID and turns ALUOp/funct into the 4-bit
//   ALU control code. It applies EX/MEM and MEM/WB forwarding to the latched
//   rs/rt values and drives the ALU operands. It also detects load-use hazards
//   and inserts bubbles.
//
// Ports
//   clk, reset                     clock, async active-high reset
//   id_*                           decoded instruction from ID
//   stall, flush                   hold stage / kill incoming instruction
//   exmem_*, memwb_*               forwarding sources
//   alu_a, alu_b, alu_control      ALU drive (operands combinational, code registered)
//   ex_valid, ex_dest, ex_*        EX-stage instruction status and control bits
//   ex_store_data                  forwarded rt value for stores
//   load_use_stall                 hold request to PC and IF/ID
//   illegal_funct                  registered: funct not recognised
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_shamt,
  input  logic [5:0]      id_funct,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_dst,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic            ex_valid,
  output logic [4:0]      ex_dest,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_stall,
  output logic            illegal_funct
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b1011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  logic            valid_q;
  logic [XLEN-1:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]      rs_q, rt_q, dest_q, shamt_q;
  logic            alu_src_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] fwd_rs, fwd_rt;
  logic            is_shift;
  logic            load_bubble;

  // ALU control decode
  always_comb begin
    alu_ctrl_d = ALU_ADD;
    illegal_d  = 1'b0;
    unique case (id_alu_op)
      2'b00: alu_ctrl_d = ALU_ADD;
      2'b01: alu_ctrl_d = ALU_SUB;
      2'b11: alu_ctrl_d = ALU_OR;
      default: begin
        case (id_funct)
          6'b100000: alu_ctrl_d = ALU_ADD;
          6'b100010: alu_ctrl_d = ALU_SUB;
          6'b100100: alu_ctrl_d = ALU_AND;
          6'b100101: alu_ctrl_d = ALU_OR;
          6'b100110: alu_ctrl_d = ALU_XOR;
          6'b100111: alu_ctrl_d = ALU_NOR;
          6'b101010: alu_ctrl_d = ALU_SLT;
          6'b000000: alu_ctrl_d = ALU_SLL;
          6'b000010: alu_ctrl_d = ALU_SRL;
          6'b000011: alu_ctrl_d = ALU_SRA;
          6'b011000: alu_ctrl_d = ALU_MUL;
          6'b011010: alu_ctrl_d = ALU_DIV;
          default: begin
            alu_ctrl_d = ALU_ADD;
            // only a real instruction can be flagged illegal
            illegal_d  = id_valid;
          end
        endcase
      end
    endcase
  end

  // Forwarding: EX/MEM takes priority over MEM/WB, and $0 is never forwarded
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && (exmem_rd == rs_q) && (rs_q != 5'd0))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd == rs_q) && (rs_q != 5'd0))
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd == rt_q) && (rt_q != 5'd0))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd == rt_q) && (rt_q != 5'd0))
      fwd_rt = memwb_result;
  end

  assign is_shift = (alu_ctrl_q == ALU_SLL) || (alu_ctrl_q == ALU_SRL) ||
                    (alu_ctrl_q == ALU_SRA);

  // Shifts operate on rt; the shift amount is placed at bits [10:6] of b
  assign alu_a = is_shift ? fwd_rt : fwd_rs;
  assign alu_b = is_shift ? {{(XLEN-11){1'b0}}, shamt_q, 6'b0}
                          : (alu_src_q ? imm_q : fwd_rt);

  assign alu_control   = alu_ctrl_q;
  assign ex_valid      = valid_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;
  assign ex_mem_to_reg = valid_q & mem_to_reg_q;
  assign ex_store_data = fwd_rt;
  assign illegal_funct = illegal_q;

  assign load_use_stall = ex_mem_read && (dest_q != 5'd0) && id_valid &&
                          ((dest_q == id_rs) || (dest_q == id_rt));

  // flush beats stall; a load-use bubble only goes in when not stalled
  assign load_bubble = flush || (!stall && load_use_stall);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= 5'd0;
      rt_q         <= 5'd0;
      dest_q       <= 5'd0;
      shamt_q      <= 5'd0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      illegal_q    <= 1'b0;
    end else if (load_bubble) begin
      valid_q      <= 1'b0;
      dest_q       <= 5'd0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      illegal_q    <= 1'b0;
    end else if (!stall) begin
      valid_q      <= id_valid;
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
      rs_q         <= id_rs;
      rt_q         <= id_rt;
      dest_q       <= id_reg_dst ? id_rd : id_rt;
      shamt_q      <= id_shamt;
      alu_src_q    <= id_alu_src;
      reg_write_q  <= id_reg_write;
      mem_read_q   <= id_mem_read;
      mem_write_q  <= id_mem_write;
      mem_to_reg_q <= id_mem_to_reg;
      alu_ctrl_q   <= alu_ctrl_d;
      illegal_q    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_dest;
  logic        load_use_stall, illegal_funct;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall),
    .illegal_funct(illegal_funct)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_funct = 0; id_alu_op = 0;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  // R-type instruction presented in ID
  task automatic rtype(input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rs_d, input logic [31:0] rt_d);
    clear_id();
    id_valid = 1; id_alu_op = 2'b10; id_funct = funct; id_reg_dst = 1; id_reg_write = 1;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rs_d; id_rt_data = rt_d;
  endtask

  // {funct, expected code, expected illegal}
  logic [10:0] fvec [0:12] = '{
    {6'b100000, 4'b0010, 1'b0}, {6'b100010, 4'b0110, 1'b0}, {6'b100100, 4'b0000, 1'b0},
    {6'b100101, 4'b0001, 1'b0}, {6'b100110, 4'b0100, 1'b0}, {6'b100111, 4'b1100, 1'b0},
    {6'b101010, 4'b0111, 1'b0}, {6'b000000, 4'b1000, 1'b0}, {6'b000010, 4'b1001, 1'b0},
    {6'b000011, 4'b1010, 1'b0}, {6'b011000, 4'b0101, 1'b0}, {6'b011010, 4'b1011, 1'b0},
    {6'b010101, 4'b0010, 1'b1}
  };

  initial begin
    reset = 1; stall = 0; flush = 0;
    clear_id();
    clear_fwd();
    #2;
    check("rst_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_ctrl", {28'b0, alu_control}, 32'h2);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_dest", {27'b0, ex_dest}, 32'd0);
    check("rst_ill", {31'b0, illegal_funct}, 32'd0);
    check("rst_rw", {31'b0, ex_reg_write}, 32'd0);
    @(negedge clk);
    reset = 0;

    // add $3,$1,$2
    rtype(6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    step();
    check("add_ctrl", {28'b0, alu_control}, 32'h2);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_dest", {27'b0, ex_dest}, 32'd3);
    check("add_rw", {31'b0, ex_reg_write}, 32'd1);
    check("add_valid", {31'b0, ex_valid}, 32'd1);
    check("add_store", ex_store_data, 32'd7);

    // sll $4,$2,3
    rtype(6'b000000, 5'd0, 5'd2, 5'd4, 32'h0, 32'h1);
    id_shamt = 5'd3;
    step();
    check("sll_a", alu_a, 32'h1);
    check("sll_b", alu_b, 32'h000000C0);
    check("sll_ctrl", {28'b0, alu_control}, 32'h8);

    // forwarding priority on rs=$1, rt=$2
    rtype(6'b100000, 5'd1, 5'd2, 5'd7, 32'h11, 32'h22);
    step();
    exmem_reg_write = 1; exmem_rd = 5'd1; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd1; memwb_result = 32'hBB;
    #1;
    check("fwd_both_a", alu_a, 32'hAA);
    check("fwd_both_b", alu_b, 32'h22);
    exmem_reg_write = 0;
    #1;
    check("fwd_memwb_a", alu_a, 32'hBB);
    memwb_rd = 5'd2;
    #1;
    check("fwd_rt_a", alu_a, 32'h11);
    check("fwd_rt_b", alu_b, 32'hBB);
    check("fwd_rt_store", ex_store_data, 32'hBB);
    clear_fwd();

    // rs=$0 never forwards
    rtype(6'b100000, 5'd0, 5'd2, 5'd7, 32'h33, 32'h44);
    step();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBB;
    #1;
    check("r0_a", alu_a, 32'h33);
    clear_fwd();

    // addi: immediate operand, I-type dest = rt
    clear_id();
    id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_reg_write = 1;
    id_rs = 5'd1; id_rt = 5'd9; id_rd = 5'd12; id_rs_data = 32'h10; id_imm = 32'hFFFFFFF0;
    step();
    check("addi_b", alu_b, 32'hFFFFFFF0);
    check("addi_a", alu_a, 32'h10);
    check("addi_dest", {27'b0, ex_dest}, 32'd9);
    id_alu_op = 2'b01;
    step();
    check("aluop01", {28'b0, alu_control}, 32'h6);
    id_alu_op = 2'b11;
    step();
    check("aluop11", {28'b0, alu_control}, 32'h1);

    // load-use: lw $2 in EX, add $5,$2,$3 in ID
    clear_id();
    id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_reg_write = 1; id_mem_read = 1;
    id_mem_to_reg = 1; id_rs = 5'd1; id_rt = 5'd2; id_imm = 32'd4;
    step();
    check("lw_mr", {31'b0, ex_mem_read}, 32'd1);
    check("lw_dest", {27'b0, ex_dest}, 32'd2);
    rtype(6'b100000, 5'd2, 5'd3, 5'd5, 32'h99, 32'h3);
    #1;
    check("lu_stall", {31'b0, load_use_stall}, 32'd1);
    step();
    check("lu_bubble", {31'b0, ex_valid}, 32'd0);
    check("lu_bub_mr", {31'b0, ex_mem_read}, 32'd0);
    check("lu_clear", {31'b0, load_use_stall}, 32'd0);
    step();
    memwb_reg_write = 1; memwb_rd = 5'd2; memwb_result = 32'h1234;
    #1;
    check("lu_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_fwd_a", alu_a, 32'h1234);
    check("lu_dest", {27'b0, ex_dest}, 32'd5);
    clear_fwd();

    // flush + stall together loads a bubble
    rtype(6'b100010, 5'd1, 5'd2, 5'd6, 32'h50, 32'h20);
    stall = 1; flush = 1;
    step();
    check("fl_valid", {31'b0, ex_valid}, 32'd0);
    check("fl_ctrl", {28'b0, alu_control}, 32'h2);
    stall = 0; flush = 0;
    step();
    check("sub_ctrl", {28'b0, alu_control}, 32'h6);
    // stall alone holds everything
    stall = 1;
    rtype(6'b100100, 5'd4, 5'd5, 5'd8, 32'h77, 32'h88);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_valid", {31'b0, ex_valid}, 32'd1);
      check("st_ctrl", {28'b0, alu_control}, 32'h6);
      check("st_a", alu_a, 32'h50);
      check("st_b", alu_b, 32'h20);
      check("st_dest", {27'b0, ex_dest}, 32'd6);
    end
    stall = 0;

    // funct decode table
    for (int i = 0; i < 13; i++) begin
      logic [10:0] v;
      v = fvec[i];
      rtype(v[10:5], 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
      step();
      check("funct_ctrl", {28'b0, alu_control}, {28'b0, v[4:1]});
      check("funct_ill", {31'b0, illegal_funct}, {31'b0, v[0]});
    end

    // funct 111111 is illegal, then async reset clears it mid-cycle
    rtype(6'b111111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    step();
    check("ill_ctrl", {28'b0, alu_control}, 32'h2);
    check("ill_flag", {31'b0, illegal_funct}, 32'd1);
    #3;
    reset = 1;
    #1;
    check("arst_ill", {31'b0, illegal_funct}, 32'd0);
    check("arst_valid", {31'b0, ex_valid}, 32'd0);
    check("arst_ctrl", {28'b0, alu_control}, 32'h2);
    @(negedge clk);
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
